// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame states, frame length and parity helper for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam int PS2_FRAME_BITS = 11;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_input_filter.sv
// ps2_input_filter: 2-FF synchroniser plus run-length filter for one PS/2 pin
module ps2_input_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);
  logic [1:0] r_sync;
  logic [3:0] r_count;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync  <= 2'b11;
      r_count <= '0;
      o_level <= 1'b1;
      o_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      o_fall <= 1'b0;
      if (r_sync[1] == o_level) r_count <= '0;
      else if (r_count == 4'(FILTER_CYCLES - 1)) begin
        o_level <= r_sync[1];
        o_fall  <= ~r_sync[1];
        r_count <= '0;
      end else r_count <= r_count + 4'd1;
    end
  end
endmodule

// File: rtl/ps2_keyboard_receiver.sv
// ps2_keyboard_receiver: PS/2 frame deserialiser with scancode latch, IRQ1 and clock inhibit
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       clear_keycode,
  input  logic       clock_enable_n,
  output logic [7:0] scancode,
  output logic       irq,
  output logic       ps2_clock_drive_low,
  output logic       frame_error
);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DATA_BITS = PS2_FRAME_BITS - 3;
  ps2_state_t r_state, w_next;
  logic [2:0]    r_bit_count;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_timer;
  logic w_fall, w_data, w_unused_clock_level, w_unused_data_fall;
  logic w_timeout, w_done, w_valid;

  ps2_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clock_filter (
    .i_clock(clock), .i_reset(reset), .i_pin(ps2_clock),
    .o_level(w_unused_clock_level), .o_fall(w_fall)
  );
  ps2_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .i_clock(clock), .i_reset(reset), .i_pin(ps2_data),
    .o_level(w_data), .o_fall(w_unused_data_fall)
  );

  assign w_timeout = (r_state != IDLE) && !w_fall && !clock_enable_n && (r_timer == TW'(TIMEOUT_CYCLES));
  assign w_done    = (r_state == STOP) && w_fall && !clock_enable_n;
  assign w_valid   = w_done && w_data && (r_parity == odd_parity(r_shift));
  assign ps2_clock_drive_low = irq | clock_enable_n;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_fall && !w_data) w_next = DATA;
      DATA:   if (w_fall && r_bit_count == 3'(DATA_BITS - 1)) w_next = PARITY;
      PARITY: if (w_fall) w_next = STOP;
      STOP:   if (w_fall) w_next = IDLE;
    endcase
    if (w_timeout || clock_enable_n) w_next = IDLE;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_count <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_timer     <= '0;
      scancode    <= '0;
      irq         <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      r_timer <= (r_state == IDLE || w_fall) ? '0 : r_timer + TW'(1);
      if (w_fall && r_state == IDLE) r_bit_count <= '0;
      if (w_fall && r_state == DATA) begin
        r_shift     <= {w_data, r_shift[7:1]};
        r_bit_count <= r_bit_count + 3'd1;
      end
      if (w_fall && r_state == PARITY) r_parity <= w_data;
      // clear wins over a frame finishing in the same cycle
      if (clear_keycode) begin
        scancode    <= '0;
        irq         <= 1'b0;
        frame_error <= 1'b0;
      end else begin
        if (w_valid && !irq) begin
          scancode <= r_shift;
          irq      <= 1'b1;
        end
        if ((w_done && (!w_valid || irq)) || w_timeout) frame_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb_ps2_keyboard_receiver: directed frame scenarios against hand-computed scancode/irq/error values
module tb_ps2_keyboard_receiver;
  localparam int FILT = 2;
  localparam int TMO  = 200;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic       clear_keycode = 1'b0;
  logic       clock_enable_n = 1'b0;
  logic [7:0] scancode;
  logic       irq, ps2_clock_drive_low, frame_error;
  int n_pass = 0;
  int n_total = 0;

  ps2_keyboard_receiver #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .clear_keycode(clear_keycode), .clock_enable_n(clock_enable_n),
    .scancode(scancode), .irq(irq), .ps2_clock_drive_low(ps2_clock_drive_low),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data  = b;
    ps2_clock = 1'b1;
    repeat (glitch ? 4 : 3) @(negedge clock);
    if (glitch) begin
      ps2_clock = 1'b0;
      @(negedge clock);
      ps2_clock = 1'b1;
      repeat (3) @(negedge clock);
    end
    ps2_clock = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic g);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], g && (i == 2 || i == 5));
    send_bit(p, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic do_clear();
    clear_keycode = 1'b1;
    @(negedge clock);
    clear_keycode = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_total++; if (scancode !== 8'h00) $display("FAIL reset_scancode got %h want 00", scancode); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
    n_total++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error got %b want 0", frame_error); else n_pass++;
    n_total++; if (ps2_clock_drive_low !== 1'b0) $display("FAIL reset_drive_low got %b want 0", ps2_clock_drive_low); else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_valid_frame();
    send_frame(8'h55, 1'b1, 1'b0);
    n_total++; if (scancode !== 8'h55) $display("FAIL valid_scancode got %h want 55", scancode); else n_pass++;
    n_total++; if (irq !== 1'b1) $display("FAIL valid_irq got %b want 1", irq); else n_pass++;
    n_total++; if (frame_error !== 1'b0) $display("FAIL valid_frame_error got %b want 0", frame_error); else n_pass++;
    n_total++; if (ps2_clock_drive_low !== 1'b1) $display("FAIL valid_drive_low got %b want 1", ps2_clock_drive_low); else n_pass++;
    do_clear();
    n_total++; if (scancode !== 8'h00) $display("FAIL clear_scancode got %h want 00", scancode); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL clear_irq got %b want 0", irq); else n_pass++;
    n_total++; if (ps2_clock_drive_low !== 1'b0) $display("FAIL clear_drive_low got %b want 0", ps2_clock_drive_low); else n_pass++;
  endtask

  task automatic test_parity_error();
    send_frame(8'h55, 1'b0, 1'b0);
    n_total++; if (irq !== 1'b0) $display("FAIL parity_irq got %b want 0", irq); else n_pass++;
    n_total++; if (scancode !== 8'h00) $display("FAIL parity_scancode got %h want 00", scancode); else n_pass++;
    n_total++; if (frame_error !== 1'b1) $display("FAIL parity_frame_error got %b want 1", frame_error); else n_pass++;
    do_clear();
    n_total++; if (frame_error !== 1'b0) $display("FAIL parity_error_clear got %b want 0", frame_error); else n_pass++;
  endtask

  task automatic test_overrun();
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    n_total++; if (scancode !== 8'h1C) $display("FAIL overrun_scancode got %h want 1c", scancode); else n_pass++;
    n_total++; if (irq !== 1'b1) $display("FAIL overrun_irq got %b want 1", irq); else n_pass++;
    n_total++; if (frame_error !== 1'b1) $display("FAIL overrun_frame_error got %b want 1", frame_error); else n_pass++;
    do_clear();
  endtask

  task automatic test_timeout();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    repeat (TMO + 10) @(negedge clock);
    n_total++; if (frame_error !== 1'b1) $display("FAIL timeout_frame_error got %b want 1", frame_error); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL timeout_irq got %b want 0", irq); else n_pass++;
    do_clear();
    send_frame(8'h5A, 1'b1, 1'b0);
    n_total++; if (scancode !== 8'h5A) $display("FAIL after_timeout_scancode got %h want 5a", scancode); else n_pass++;
    n_total++; if (frame_error !== 1'b0) $display("FAIL after_timeout_frame_error got %b want 0", frame_error); else n_pass++;
    do_clear();
  endtask

  task automatic test_glitch();
    send_frame(8'h29, 1'b0, 1'b1);
    n_total++; if (scancode !== 8'h29) $display("FAIL glitch_scancode got %h want 29", scancode); else n_pass++;
    n_total++; if (irq !== 1'b1) $display("FAIL glitch_irq got %b want 1", irq); else n_pass++;
    n_total++; if (frame_error !== 1'b0) $display("FAIL glitch_frame_error got %b want 0", frame_error); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    reset     = 1'b1;
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    repeat (2) @(negedge clock);
    n_total++; if (scancode !== 8'h00) $display("FAIL midreset_scancode got %h want 00", scancode); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL midreset_irq got %b want 0", irq); else n_pass++;
    n_total++; if (frame_error !== 1'b0) $display("FAIL midreset_frame_error got %b want 0", frame_error); else n_pass++;
    n_total++; if (ps2_clock_drive_low !== 1'b0) $display("FAIL midreset_drive_low got %b want 0", ps2_clock_drive_low); else n_pass++;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    send_frame(8'h29, 1'b0, 1'b0);
    n_total++; if (scancode !== 8'h29) $display("FAIL post_reset_scancode got %h want 29", scancode); else n_pass++;
    n_total++; if (irq !== 1'b1) $display("FAIL post_reset_irq got %b want 1", irq); else n_pass++;
    do_clear();
  endtask

  task automatic test_inhibit();
    clock_enable_n = 1'b1;
    @(negedge clock);
    n_total++; if (ps2_clock_drive_low !== 1'b1) $display("FAIL inhibit_drive_low got %b want 1", ps2_clock_drive_low); else n_pass++;
    send_frame(8'h5A, 1'b1, 1'b0);
    n_total++; if (irq !== 1'b0) $display("FAIL inhibit_irq got %b want 0", irq); else n_pass++;
    n_total++; if (scancode !== 8'h00) $display("FAIL inhibit_scancode got %h want 00", scancode); else n_pass++;
    n_total++; if (frame_error !== 1'b0) $display("FAIL inhibit_frame_error got %b want 0", frame_error); else n_pass++;
    clock_enable_n = 1'b0;
    @(negedge clock);
    n_total++; if (ps2_clock_drive_low !== 1'b0) $display("FAIL release_drive_low got %b want 0", ps2_clock_drive_low); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_overrun();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_inhibit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
